// File: rtl/dfe_buf_pkg.sv
// Shared types and helpers for the DFE output buffer.
// One FIFO entry is a decimated sample plus its overflow/underflow tags.
package dfe_buf_pkg;

  localparam int DATA_WIDTH = 16;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] data;
    logic                         ovf;
    logic                         unf;
  } buf_entry_t;

  // Ceiling log2; returns at least 1 so that pointer vectors are never zero-width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/dfe_fifo_ram.sv
// DEPTH x buf_entry_t register file.
// It has one synchronous write port and one asynchronous read port. The storage is not reset.
module dfe_fifo_ram
  import dfe_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  buf_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output buf_entry_t    rdata
);

  buf_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dfe_out_buffer.sv
// Elastic show-ahead output buffer between the DFE core and its stream consumer.
// It absorbs consumer back-pressure, counts samples dropped on full and reports the fill level.
module dfe_out_buffer
  import dfe_buf_pkg::*;
#(
  parameter int DATA_WIDTH = dfe_buf_pkg::DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = 12,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      ovf_in,
  input  logic                      unf_in,
  input  logic                      flush,
  input  logic                      clr_stats,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_ovf,
  output logic                      m_unf,
  output logic [clog2(DEPTH):0]     level,
  output logic                      full,
  output logic                      almost_full,
  output logic [CNT_WIDTH-1:0]      drop_cnt,
  output logic                      drop_sticky
);

  localparam int PW = clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;
  logic          push;
  logic          drop;
  logic          not_empty;
  buf_entry_t    wr_entry;
  buf_entry_t    head;

  // Stream handshake: a sample transfers in every cycle where m_valid && m_ready.
  // m_valid is decoded from the registered level only, so it never depends on valid_in or m_ready.
  // Once m_valid is raised, it and the head entry hold until that transfer happens or a flush occurs.
  assign not_empty = (level != '0);
  assign m_valid   = not_empty;
  assign pop       = not_empty && m_ready;

  // A full FIFO still accepts a write when a pop frees an entry in the same cycle.
  assign push = valid_in && !flush && (!full || pop);
  assign drop = valid_in && !flush && full && !pop;

  assign full        = (level == LW'(DEPTH));
  assign almost_full = (level >= LW'(AFULL_TH));

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = data_in;
    wr_entry.ovf  = ovf_in;
    wr_entry.unf  = unf_in;
  end

  dfe_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // The RAM is not reset, so the head fields are masked while the FIFO is empty.
  always_comb begin
    m_data = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    if (not_empty) begin
      m_data = head.data;
      m_ovf  = head.ovf;
      m_unf  = head.unf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as clr_stats is counted after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt    <= '0;
      drop_sticky <= 1'b0;
    end else if (clr_stats) begin
      drop_cnt    <= drop ? CNT_WIDTH'(1) : '0;
      drop_sticky <= drop;
    end else if (drop) begin
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
      drop_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dfe_out_buffer.sv
// Scoreboard bench for dfe_out_buffer.
// A queue model predicts the level, flags, statistics and the order in which samples leave the buffer.
module tb_dfe_out_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int ATH   = 12;
  localparam int CW    = 8;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ovf_in;
  logic          unf_in;
  logic          flush;
  logic          clr_stats;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_ovf;
  logic          m_unf;
  logic [4:0]    level;
  logic          full;
  logic          almost_full;
  logic [CW-1:0] drop_cnt;
  logic          drop_sticky;

  // Scoreboard state: the expected FIFO contents as {data, ovf, unf}, plus the expected statistics.
  logic [DW+1:0] exp_q[$];
  int unsigned   m_cnt;
  bit            m_sticky;
  logic [DW+1:0] last_pop;
  int            checks;
  int            failures;

  dfe_out_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_TH   (ATH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ovf_in      (ovf_in),
    .unf_in      (unf_in),
    .flush       (flush),
    .clr_stats   (clr_stats),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_ovf       (m_ovf),
    .m_unf       (m_unf),
    .level       (level),
    .full        (full),
    .almost_full (almost_full),
    .drop_cnt    (drop_cnt),
    .drop_sticky (drop_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle. The task applies the inputs and compares the DUT outputs with the model before the edge.
  // It then updates the model and waits until just after the edge.
  task automatic step(input bit vin, input logic [DW-1:0] d, input bit o, input bit u,
                      input bit rdy, input bit fl = 1'b0, input bit clr = 1'b0);
    bit            pop;
    logic [DW+1:0] e;
    valid_in  = vin;
    data_in   = d;
    ovf_in    = o;
    unf_in    = u;
    m_ready   = rdy;
    flush     = fl;
    clr_stats = clr;
    #1;
    pop = (exp_q.size() != 0) && rdy;
    chk("m_valid", m_valid, exp_q.size() != 0);
    chk("level", level, exp_q.size());
    chk("full", full, exp_q.size() == DEPTH);
    chk("almost_full", almost_full, exp_q.size() >= ATH);
    chk("drop_cnt", drop_cnt, m_cnt);
    chk("drop_sticky", drop_sticky, m_sticky);
    if (exp_q.size() == 0) chk("empty_head", {m_data, m_ovf, m_unf}, 0);
    else                   chk("head", {m_data, m_ovf, m_unf}, exp_q[0]);
    if (clr) begin
      m_cnt    = 0;
      m_sticky = 0;
    end
    if (fl) begin
      exp_q.delete();
    end else begin
      if (pop) begin
        e        = exp_q.pop_front();
        last_pop = e;
        chk("pop_data", {m_data, m_ovf, m_unf}, e);
      end
      if (vin) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back({d, o, u});
        end else begin
          if (m_cnt < 255) m_cnt++;
          m_sticky = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_head"}, {m_data, m_ovf, m_unf}, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_sticky"}, drop_sticky, 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_cnt     = 0;
    m_sticky  = 0;
    last_pop  = '0;
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    data_in   = '0;
    ovf_in    = 1'b0;
    unf_in    = 1'b0;
    flush     = 1'b0;
    clr_stats = 1'b0;
    m_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic stream: each sample is visible one cycle after it is accepted, and level stays at most 1.
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    chk("basic_lvl1", level <= 1, 1);
    step(1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
    chk("basic_lvl2", level <= 1, 1);
    step(1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    chk("basic_lvl3", level <= 1, 1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("basic_last", last_pop, {16'h7FFF, 1'b0, 1'b1});
    idle(1'b1, 2);

    // Fill and drop: 20 pushes into a 16-entry FIFO give 4 drops, then the drain returns 0..15.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      if (i == 11) chk("afull_at_12", almost_full, 1);
      if (i == 15) chk("full_at_16", full, 1);
    end
    chk("fill_drop_cnt", drop_cnt, 4);
    chk("fill_sticky", drop_sticky, 1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("drain_order", last_pop, {DW'(i), 2'b00});
    end
    idle(1'b1, 1);

    // Full FIFO with a pop and a push in the same cycle.
    for (int i = 0; i < 16; i++) step(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b1);
    chk("pp_level", level, 16);
    chk("pp_drop_cnt", drop_cnt, 4);
    idle(1'b1, 17);
    chk("pp_aa_last", last_pop, {16'h00AA, 2'b00});

    // Stall stability: the head holds while m_ready is low and later samples queue behind it.
    step(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      chk("stall_head", m_data, 16'h0055);
    end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("stall_pop", last_pop, {16'h0055, 2'b00});
    idle(1'b1, 7);

    // Flush with a write: the buffer empties, the write is not counted as a drop, and the next push is visible one cycle later.
    for (int i = 0; i < 7; i++) step(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_level", level, 0);
    chk("flush_m_valid", m_valid, 0);
    chk("flush_drop_cnt", drop_cnt, 4);
    step(1'b1, 16'h0321, 1'b1, 1'b1, 1'b0);
    chk("flush_next_valid", m_valid, 1);
    chk("flush_next_data", {m_data, m_ovf, m_unf}, {16'h0321, 2'b11});
    idle(1'b1, 2);

    // Saturation: fill the FIFO, then force 300 drops.
    for (int i = 0; i < 316; i++) step(1'b1, DW'($urandom_range(0, 16'hFFFF)), 1'b0, 1'b0, 1'b0);
    chk("sat_drop_cnt", drop_cnt, 255);
    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_drop_cnt", drop_cnt, 1);
    chk("clr_sticky", drop_sticky, 1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_only_cnt", drop_cnt, 0);
    chk("clr_only_sticky", drop_sticky, 0);

    // Asynchronous reset mid-stream must zero the outputs immediately, without a clock edge.
    step(1'b1, 16'h4242, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    m_cnt    = 0;
    m_sticky = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b1);
    idle(1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
